// File: rtl/rf_write_arbiter.sv
// Arbitrates execute and load writebacks onto the single register-file write port.
// Optional build macro RF_WRITE_COALESCE_EN: same-address ex/mem entries collapse into one write.
module rf_write_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int MAX_WAIT = 3,
    localparam int NUM_REGS = 2**ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic [ADDR_W-1:0]   ex_addr,
    input  logic [DATA_W-1:0]   ex_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_data,
    output logic                rf_write_enable,
    output logic [ADDR_W-1:0]   rf_write_addr,
    output logic [DATA_W-1:0]   rf_write_data,
    output logic [NUM_REGS-1:0] pending_mask
);
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic              ex_full_q, mem_full_q;
    logic [ADDR_W-1:0] ex_addr_q, mem_addr_q;
    logic [DATA_W-1:0] ex_data_q, mem_data_q;
    logic              mem_older_q, mem_older_d;
    logic [WAIT_W-1:0] ex_wait_q, ex_wait_d;
    logic              we_q;
    logic [ADDR_W-1:0] wa_q;
    logic [DATA_W-1:0] wd_q;

    logic both_full, same_addr, starved;
    logic gnt_ex, gnt_mem, coal;
    logic ex_free, mem_free, ex_load, mem_load;

    always_comb begin
        both_full = ex_full_q & mem_full_q;
        same_addr = both_full & (ex_addr_q == mem_addr_q);
        // Starvation override never reorders two writes to the same register.
        starved   = both_full & (ex_wait_q == WAIT_MAX) & ~same_addr;
        gnt_ex    = 1'b0;
        gnt_mem   = 1'b0;
        coal      = 1'b0;
`ifdef RF_WRITE_COALESCE_EN
        if (same_addr) begin
            coal = 1'b1;
            if (mem_older_q) gnt_ex  = 1'b1;
            else             gnt_mem = 1'b1;
        end else
`endif
        if (starved)         gnt_ex  = 1'b1;
        else if (same_addr) begin
            if (mem_older_q) gnt_mem = 1'b1;
            else             gnt_ex  = 1'b1;
        end
        else if (mem_full_q) gnt_mem = 1'b1;
        else if (ex_full_q)  gnt_ex  = 1'b1;
    end

    assign ex_free   = gnt_ex | coal;
    assign mem_free  = gnt_mem | coal;
    assign ex_ready  = rst & (~ex_full_q | ex_free);
    assign mem_ready = rst & (~mem_full_q | mem_free);
    assign ex_load   = ex_valid & ex_ready;
    assign mem_load  = mem_valid & mem_ready;

    always_comb begin
        mem_older_d = mem_older_q;
        if (coal)                      mem_older_d = 1'b0;
        // A simultaneous load counts mem as the older entry.
        if (ex_load && mem_load)       mem_older_d = 1'b1;
        else if (mem_load)             mem_older_d = 1'b0;
        else if (ex_load)              mem_older_d = 1'b1;

        ex_wait_d = '0;
        if (ex_full_q && !ex_free)
            ex_wait_d = (ex_wait_q == WAIT_MAX) ? ex_wait_q : ex_wait_q + WAIT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_full_q   <= 1'b0;
            mem_full_q  <= 1'b0;
            ex_addr_q   <= '0;
            mem_addr_q  <= '0;
            ex_data_q   <= '0;
            mem_data_q  <= '0;
            mem_older_q <= 1'b0;
            ex_wait_q   <= '0;
            we_q        <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
        end else begin
            mem_older_q <= mem_older_d;
            ex_wait_q   <= ex_wait_d;
            if (ex_free)  ex_full_q  <= 1'b0;
            if (mem_free) mem_full_q <= 1'b0;
            if (ex_load) begin
                ex_full_q <= 1'b1;
                ex_addr_q <= ex_addr;
                ex_data_q <= ex_data;
            end
            if (mem_load) begin
                mem_full_q <= 1'b1;
                mem_addr_q <= mem_addr;
                mem_data_q <= mem_data;
            end
            we_q <= gnt_ex | gnt_mem;
            if (gnt_ex) begin
                wa_q <= ex_addr_q;
                wd_q <= ex_data_q;
            end else if (gnt_mem) begin
                wa_q <= mem_addr_q;
                wd_q <= mem_data_q;
            end
        end
    end

    assign rf_write_enable = we_q;
    assign rf_write_addr   = wa_q;
    assign rf_write_data   = wd_q;

    // The in-flight write stays visible until the register file captures it.
    always_comb begin
        pending_mask = '0;
        if (ex_full_q)  pending_mask[ex_addr_q]  = 1'b1;
        if (mem_full_q) pending_mask[mem_addr_q] = 1'b1;
        if (we_q)       pending_mask[wa_q]       = 1'b1;
    end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: execute results (ex) and memory loads (mem).
- Each source has a one-entry holding slot with a valid/ready handshake.
- The arbiter drains one slot per cycle into registered write-port outputs that drive the register file.
- Publishes a pending-write mask so decode can stall on registers with writes still in flight.

Parameters:
DATA_W, 16, write data width
ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W
MAX_WAIT, 3, max consecutive cycles a full ex slot may lose arbitration before it is forced to win

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
ex_valid  input  1  execute writeback request
ex_ready  output  1  ex slot can accept this cycle
ex_addr  input  ADDR_W  destination register
ex_data  input  DATA_W  result
mem_valid  input  1  load writeback request
mem_ready  output  1  mem slot can accept this cycle
mem_addr  input  ADDR_W  destination register
mem_data  input  DATA_W  load data
rf_write_enable  output  1  register-file write strobe, registered
rf_write_addr  output  ADDR_W  registered write address
rf_write_data  output  DATA_W  registered write data
pending_mask  output  NUM_REGS  bit i = write to register i still in flight

Behaviour:
- Reset (rst low, asynchronous):
  - Both slots empty; age flag cleared; ex_wait counter = 0.
  - rf_write_enable = 0, rf_write_addr = 0, rf_write_data = 0, pending_mask = 0.
  - ex_ready = mem_ready = 0 while rst is low.
- Reset mid-operation: held requests are discarded, no write is issued, the registered write is cancelled immediately.
- Handshake:
  - Transfer occurs when valid && ready at a rising edge.
  - xx_ready = slot empty OR slot granted this cycle, so a new request is accepted in the same cycle the old one drains.
  - Requester must hold addr/data stable while valid && !ready.
- Arbitration, combinational, one grant per cycle:
  1. If both slots are full and ex_wait == MAX_WAIT, grant ex.
  2. Else if both slots are full and hold the same address, grant the older slot. The age flag records which slot loaded first; on a same-cycle load, mem counts as older.
  3. Else if the mem slot is full, grant mem.
  4. Else if the ex slot is full, grant ex.
  5. Otherwise no grant.
- Rule 1 overrides the same-address ordering only for different addresses. For the same address, ordering always wins and ex_wait saturates.
- ex_wait:
  - +1 (saturating at MAX_WAIT) each cycle the ex slot is full and not granted.
  - Cleared when ex is granted or the ex slot is empty.
- Output register: on the rising edge after a grant, rf_write_enable = 1 with the granted addr/data for exactly one cycle. Otherwise rf_write_enable = 0 and addr/data hold their last values.
- Latency: accepted at edge N, rf_write_enable high in cycle N+1 at best. Back-to-back writes are possible at one per cycle.
- Throughput: both slots full means 2 consecutive write cycles.
- pending_mask = decode(ex slot addr if full) | decode(mem slot addr if full) | decode(rf_write_addr if rf_write_enable). The register file captures on the falling edge of the write cycle, so the entry is included through that cycle.
- Writes to every address (including 0) are performed; no register is special-cased.

Optional Feature:
RF_WRITE_COALESCE_EN
- Defined: if both slots are full with the same address, the older slot is discarded without writing and the younger slot is granted. Both slots free in the same cycle and both readies are asserted. Age flag and ex_wait are cleared.
- Not defined: same-address entries are written in age order as two separate writes (rule 2).

Test Plan:
- Reset, then ex_valid=1, addr=5, data=0x1234 for one accept → next cycle rf_write_enable=1, addr=5, data=0x1234; pending_mask=0x20 for 2 cycles, then 0x00.
- mem (addr=2, 0xAAAA) and ex (addr=3, 0x5555) accepted the same cycle → writes in consecutive cycles: addr 2 then addr 3.
- mem_valid held high with a new address every cycle, ex slot full (addr=1) → ex written on the 4th cycle of waiting (MAX_WAIT=3); mem stream resumes afterwards.
- ex (addr=4, 0x0001) accepted one cycle before mem (addr=4, 0x0002), both pending → writes 0x0001 then 0x0002 to reg 4. With RF_WRITE_COALESCE_EN → a single write of 0x0002.
- Both slots full, rst driven low mid-cycle → rf_write_enable drops immediately; after release no writes occur, pending_mask=0, both readies=1.
- ex_valid held high with a new request every cycle, mem idle → ex_ready stays 1, one write per cycle, no bubbles.
